lcd_hex_writer: RTL and testbench

LCD_HEX_WRITER -- requirements
Module: lcd_hex_writer

---
 rtl/lcd_hex_writer_pkg.sv | 25 ++
 rtl/lcd_hex_writer_if.sv | 24 ++
 rtl/lcd_hex_writer_nib2ascii.sv | 15 +
 rtl/lcd_hex_writer.sv | 130 +++++++++++++
 tb/tb_lcd_hex_writer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_hex_writer_pkg.sv
// Shared types and constants for the LCD hex writer.
// LCD_HEX_PREFIX_EN adds a "0x" prefix ahead of the four digits.
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [6:0] LINE1_BASE  = 7'h00;
  localparam logic [6:0] LINE2_BASE  = 7'h40;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_X     = 8'h78;

`ifdef LCD_HEX_PREFIX_EN
  localparam int CHAR_CNT = 6;
`else
  localparam int CHAR_CNT = 4;
`endif

  localparam logic [2:0] LAST_CHAR = 3'(CHAR_CNT - 1);

endpackage

// File: rtl/lcd_hex_writer_if.sv
// Character link between the hex writer and the 2x16 LCD driver.
// The writer is the master; the driver answers with done.
interface lcd_hex_writer_if;

  logic [6:0] index;
  logic [7:0] ch;
  logic       go;
  logic       done;

  modport master (
    output index,
    output ch,
    output go,
    input  done
  );

  modport slave (
    input  index,
    input  ch,
    input  go,
    output done
  );

endinterface

// File: rtl/lcd_hex_writer_nib2ascii.sv
// Combinational nibble to uppercase hex ASCII converter.
// 0-9 map to 0x30-0x39, A-F map to 0x41-0x46.
module nib2ascii (
  input  logic [3:0] nib,
  output logic [7:0] asc
);

  always_comb begin
    if (nib < 4'd10)
      asc = 8'h30 + {4'h0, nib};
    else
      asc = 8'h37 + {4'h0, nib};
  end

endmodule

// File: rtl/lcd_hex_writer.sv
// Writes a 16-bit value as hex characters to a 2x16 LCD driver.
// LCD_HEX_PREFIX_EN prepends "0x" (six characters instead of four).
module lcd_hex_writer
  import lcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] val,
  input  logic        line,
  input  logic [3:0]  col,
  input  logic        wr,
  output logic        busy,
  output logic        cmplt,
  output logic [6:0]  lcd_index,
  output logic [7:0]  lcd_char,
  output logic        lcd_go,
  input  logic        lcd_done
);

  state_t      state;
  state_t      state_nx;
  logic [2:0]  cnt;
  logic [2:0]  cnt_nx;
  logic [15:0] val_q;
  logic        line_q;
  logic [3:0]  col_q;
  logic [2:0]  dig;
  logic [3:0]  nib;
  logic [7:0]  asc;
  logic [7:0]  ch;
  logic [3:0]  colk;
  logic [6:0]  base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      val_q  <= 16'h0000;
      line_q <= 1'b0;
      col_q  <= 4'h0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && wr) begin
        val_q  <= val;
        line_q <= line;
        col_q  <= col;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (wr) begin
          state_nx = XFER;
          cnt_nx   = 3'd0;
        end
      end
      XFER: begin
        if (lcd_done) begin
          if (cnt == LAST_CHAR)
            state_nx = FIN;
          else
            cnt_nx = cnt + 3'd1;
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Digit position within val, skipping the prefix slots
`ifdef LCD_HEX_PREFIX_EN
  assign dig = cnt - 3'd2;
`else
  assign dig = cnt;
`endif

  always_comb begin
    unique case (dig)
      3'd0:    nib = val_q[15:12];
      3'd1:    nib = val_q[11:8];
      3'd2:    nib = val_q[7:4];
      default: nib = val_q[3:0];
    endcase
  end

  nib2ascii u_nib2ascii (
    .nib (nib),
    .asc (asc)
  );

`ifdef LCD_HEX_PREFIX_EN
  always_comb begin
    unique case (cnt)
      3'd0:    ch = ASCII_ZERO;
      3'd1:    ch = ASCII_X;
      default: ch = asc;
    endcase
  end
`else
  assign ch = asc;
`endif

  // Column wraps inside the selected line
  assign colk = col_q + {1'b0, cnt};
  assign base = line_q ? LINE2_BASE : LINE1_BASE;

  always_comb begin
    busy      = 1'b0;
    cmplt     = 1'b0;
    lcd_go    = 1'b0;
    lcd_index = LINE1_BASE;
    lcd_char  = ASCII_SPACE;
    unique case (1'b1)
      (state == XFER): begin
        busy      = 1'b1;
        lcd_go    = 1'b1;
        lcd_index = base | {3'b000, colk};
        lcd_char  = ch;
      end
      (state == FIN): cmplt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lcd_hex_writer.sv
// Directed bench for lcd_hex_writer with a modelled LCD driver.
// Define LCD_HEX_PREFIX_EN to check the "0x" prefixed build.
module tb_lcd_hex_writer;

  logic        clk;
  logic        rst_n;
  logic [15:0] val;
  logic        line;
  logic [3:0]  col;
  logic        wr;
  logic        busy;
  logic        cmplt;

  lcd_hex_writer_if lcd_bus ();

  int checks = 0;
  int errors = 0;

  lcd_hex_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .val       (val),
    .line      (line),
    .col       (col),
    .wr        (wr),
    .busy      (busy),
    .cmplt     (cmplt),
    .lcd_index (lcd_bus.index),
    .lcd_char  (lcd_bus.ch),
    .lcd_go    (lcd_bus.go),
    .lcd_done  (lcd_bus.done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver model: ignores go for 500 cycles, answers 20 cycles later
  int         init_cnt;
  int         dly;
  int         done_cnt;
  logic [6:0] rec_idx[$];
  logic [7:0] rec_chr[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt     <= 0;
      dly          <= 0;
      done_cnt     <= 0;
      lcd_bus.done <= 1'b0;
      rec_idx.delete();
      rec_chr.delete();
    end else begin
      lcd_bus.done <= 1'b0;
      if (init_cnt < 500)
        init_cnt <= init_cnt + 1;
      if (dly != 0) begin
        dly <= dly - 1;
        if (dly == 1) begin
          lcd_bus.done <= 1'b1;
          done_cnt     <= done_cnt + 1;
        end
      end else if (lcd_bus.go && init_cnt >= 500
                   && !lcd_bus.done) begin
        dly <= 20;
        rec_idx.push_back(lcd_bus.index);
        rec_chr.push_back(lcd_bus.ch);
      end
    end
  end

  logic [6:0] e_idx[$];
  logic [7:0] e_chr[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cmplt"}, 32'(cmplt), 32'd0);
    chk({tag, "_go"}, 32'(lcd_bus.go), 32'd0);
    chk({tag, "_idx"}, 32'(lcd_bus.index), 32'h00);
    chk({tag, "_chr"}, 32'(lcd_bus.ch), 32'h20);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_wr(input logic [15:0] v,
                       input logic l,
                       input logic [3:0] c);
    val  = v;
    line = l;
    col  = c;
    wr   = 1'b1;
    @(negedge clk);
    wr   = 1'b0;
  endtask

  task automatic run_seq(input string tag);
    int n;
    bit seen;
    n    = 0;
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (cmplt) begin
        seen = 1;
        n++;
        chk({tag, "_busy_fin"}, 32'(busy), 32'd0);
      end
    end
    chk({tag, "_cmplt_seen"}, 32'(seen), 32'd1);
    repeat (6) begin
      @(negedge clk);
      if (cmplt) n++;
    end
    chk({tag, "_cmplt_once"}, n, 32'd1);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_go_after"}, 32'(lcd_bus.go), 32'd0);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_nchars"}, rec_idx.size(), e_idx.size());
    for (int k = 0; k < e_idx.size(); k++) begin
      if (k < rec_idx.size()) begin
        chk($sformatf("%s_idx%0d", tag, k),
            32'(rec_idx[k]), 32'(e_idx[k]));
        chk($sformatf("%s_chr%0d", tag, k),
            32'(rec_chr[k]), 32'(e_chr[k]));
      end
    end
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    val   = 16'h0;
    line  = 1'b0;
    col   = 4'h0;
    wr    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outs("rst");

    // Test 1: early wr, init hold, ignored wr while busy
`ifdef LCD_HEX_PREFIX_EN
    e_idx = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05};
    e_chr = '{8'h30, 8'h78, 8'h33, 8'h41, 8'h37, 8'h46};
`else
    e_idx = '{7'h00, 7'h01, 7'h02, 7'h03};
    e_chr = '{8'h33, 8'h41, 8'h37, 8'h46};
`endif
    @(negedge clk);
    rst_n = 1'b1;
    do_wr(16'h3A7F, 1'b0, 4'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_go", 32'(lcd_bus.go), 32'd1);
    chk("t1_idx0", 32'(lcd_bus.index), 32'(e_idx[0]));
    chk("t1_chr0", 32'(lcd_bus.ch), 32'(e_chr[0]));
    repeat (480) @(negedge clk);
    chk("t1_hold_go", 32'(lcd_bus.go), 32'd1);
    chk("t1_hold_idx", 32'(lcd_bus.index), 32'(e_idx[0]));
    chk("t1_hold_chr", 32'(lcd_bus.ch), 32'(e_chr[0]));
    chk("t1_hold_nrec", rec_idx.size(), 32'd0);
    t = 0;
    while (rec_idx.size() < 1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("t1_first_acc", 32'(rec_idx.size() >= 1), 32'd1);
    do_wr(16'h1234, 1'b1, 4'd5);
    chk("t1_busy_ign", 32'(busy), 32'd1);
    run_seq("t1");
    check_log("t1");

    // Test 2: column wrap on line 2
`ifdef LCD_HEX_PREFIX_EN
    e_idx = '{7'h4E, 7'h4F, 7'h40, 7'h41, 7'h42, 7'h43};
    e_chr = '{8'h30, 8'h78, 8'h42, 8'h45, 8'h45, 8'h46};
`else
    e_idx = '{7'h4E, 7'h4F, 7'h40, 7'h41};
    e_chr = '{8'h42, 8'h45, 8'h45, 8'h46};
`endif
    do_reset();
    do_wr(16'hBEEF, 1'b1, 4'd14);
    run_seq("t2");
    check_log("t2");

    // Test 3: reset after second done, then a fresh write
    do_reset();
    do_wr(16'h3A7F, 1'b0, 4'd0);
    t = 0;
    while (done_cnt < 2 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("t3_two_done", done_cnt, 32'd2);
    chk("t3_busy_mid", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("t3_rst");
    @(negedge clk);
    rst_n = 1'b1;
`ifdef LCD_HEX_PREFIX_EN
    e_idx = '{7'h03, 7'h04, 7'h05, 7'h06, 7'h07, 7'h08};
    e_chr = '{8'h30, 8'h78, 8'h30, 8'h30, 8'h46, 8'h46};
`else
    e_idx = '{7'h03, 7'h04, 7'h05, 7'h06};
    e_chr = '{8'h30, 8'h30, 8'h46, 8'h46};
`endif
    do_wr(16'h00FF, 1'b0, 4'd3);
    run_seq("t3");
    check_log("t3");
    #1;
    chk_reset_outs("idle_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
